// File: rtl/mem_block_ctrl_if.sv
// mem_block_ctrl_if
//   Request / fill / writeback signal bundle between a cache-side requester
//   (master) and the block memory controller (slave).
//   Request : req_valid, req_ready, req_write, req_block[12:0]
//   Fill    : rd_valid, rd_data[31:0], rd_beat[3:0], rd_last
//   Write   : wr_valid, wr_data[31:0], wr_ready
//   Status  : done (one-cycle completion pulse), busy (not idle)
interface mem_block_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [12:0] req_block;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_beat;
  logic        rd_last;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        done;
  logic        busy;

  modport master (
    output req_valid, req_write, req_block, wr_valid, wr_data,
    input  req_ready, rd_valid, rd_data, rd_beat, rd_last, wr_ready, done, busy
  );

  modport slave (
    input  req_valid, req_write, req_block, wr_valid, wr_data,
    output req_ready, rd_valid, rd_data, rd_beat, rd_last, wr_ready, done, busy
  );
endinterface

// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl
//   Block memory controller holding BLOCKS blocks of 16 x 32-bit words.
//   A request is accepted in IDLE, waits LATENCY access cycles, then either
//   streams 16 fill beats (no backpressure) or absorbs 16 writeback beats
//   (stallable via wr_valid), and finishes with a one-cycle done pulse.
//   Ports: clk, rst (synchronous, active high), bus (mem_block_ctrl_if.slave).
//   Parameters: LATENCY (1..15) access cycles, BLOCKS number of blocks.
module mem_block_ctrl #(
  parameter int LATENCY = 4,
  parameter int BLOCKS  = 8192
) (
  input logic             clk,
  input logic             rst,
  mem_block_ctrl_if.slave bus
);

  localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int ADDR_W = BLK_W + 4;
  localparam int DEPTH  = BLOCKS * 16;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [3:0]       beat_reg, beat_next;
  logic [BLK_W-1:0] block_reg, block_next;
  logic             write_reg, write_next;

  // Storage holds (data XOR word offset). A zero-initialised array therefore
  // reads back as "word j = j" for every block without any init sequencer,
  // and reset never touches it.
  logic [31:0] mem [DEPTH] = '{default: 32'd0};
  logic [31:0] rd_word_reg;

  logic [3:0]        rd_addr_beat;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      beat_reg  <= 4'd0;
      block_reg <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      beat_reg  <= beat_next;
      block_reg <= block_next;
      write_reg <= write_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    beat_next  = beat_reg;
    block_next = block_reg;
    write_next = write_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          block_next = bus.req_block[BLK_W-1:0];
          write_next = bus.req_write;
          cnt_next   = LAT_LOAD;
          state_next = LAT;
        end
      end
      LAT: begin
        if (cnt_reg == 4'd0) begin
          beat_next  = 4'd0;
          state_next = write_reg ? WR_BURST : RD_BURST;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RD_BURST: begin
        if (beat_reg == 4'd15) state_next = DONE;
        else                   beat_next  = beat_reg + 4'd1;
      end
      WR_BURST: begin
        if (bus.wr_valid) begin
          if (beat_reg == 4'd15) state_next = DONE;
          else                   beat_next  = beat_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The RAM read is registered, so the address runs one beat ahead of the
  // beat being presented: beat 0 is fetched during the final LAT cycle,
  // beat b+1 while beat b is on the bus.
  assign rd_addr_beat = (state_reg == LAT) ? 4'd0 : beat_reg + 4'd1;
  assign rd_addr      = {block_reg, rd_addr_beat};
  assign wr_addr      = {block_reg, beat_reg};
  assign wr_en        = (state_reg == WR_BURST) && bus.wr_valid && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.wr_data ^ {28'd0, beat_reg};
    rd_word_reg <= mem[rd_addr];
  end

  // Outputs
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.wr_ready  = (state_reg == WR_BURST);
  assign bus.rd_valid  = (state_reg == RD_BURST);
  assign bus.rd_beat   = bus.rd_valid ? beat_reg : 4'd0;
  assign bus.rd_last   = bus.rd_valid && (beat_reg == 4'd15);
  assign bus.rd_data   = bus.rd_valid ? (rd_word_reg ^ {28'd0, beat_reg}) : 32'd0;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// tb_mem_block_ctrl
//   Scoreboard bench for mem_block_ctrl. Fill expectations are pushed from a
//   memory model when a read request is accepted and popped per fill beat.
//   Two extra small instances exercise the LATENCY extremes.
module tb_mem_block_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_block_ctrl_if bus();
  mem_block_ctrl_if bus_l1();
  mem_block_ctrl_if bus_l15();

  mem_block_ctrl #(.LATENCY(4),  .BLOCKS(8192)) dut     (.clk(clk), .rst(rst), .bus(bus));
  mem_block_ctrl #(.LATENCY(1),  .BLOCKS(16))   dut_l1  (.clk(clk), .rst(rst), .bus(bus_l1));
  mem_block_ctrl #(.LATENCY(15), .BLOCKS(16))   dut_l15 (.clk(clk), .rst(rst), .bus(bus_l15));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: untouched words read back as their offset
  logic [31:0] model_mem [int];
  function automatic logic [31:0] model_rd(input int blk, input int beat);
    int key;
    key = blk * 16 + beat;
    if (model_mem.exists(key)) return model_mem[key];
    return 32'(beat);
  endfunction

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  beat;
  } exp_t;
  exp_t exp_q[$];

  int accept_count = 0;
  int last_acc_edge = 0;
  int done_count = 0;
  int done_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int first_l1 = -1;
  int first_l15 = -1;
  logic [31:0] first_l15_data = 32'd0;

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.req_valid && bus.req_ready) begin
      accept_count++;
      last_acc_edge = cyc + 1;
      if (!bus.req_write) begin
        for (int b = 0; b < 16; b++) begin
          e.data = model_rd(int'(bus.req_block), b);
          e.beat = 4'(b);
          exp_q.push_back(e);
        end
      end
    end
    if (bus.rd_valid) begin
      if (bus.rd_beat == 4'd0) first_cyc = cyc;
      if (bus.rd_last) last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("rd_data", bus.rd_data, e.data);
        check_eq("rd_beat", 32'(bus.rd_beat), 32'(e.beat));
        check_eq("rd_last", 32'(bus.rd_last), 32'(e.beat == 4'd15));
      end
    end else begin
      check_eq("rd_data_idle", bus.rd_data, 32'd0);
    end
    if (bus.done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (bus_l1.rd_valid && first_l1 < 0) first_l1 = cyc;
    if (bus_l15.rd_valid && first_l15 < 0) begin
      first_l15 = cyc;
      first_l15_data = bus_l15.rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_count < target && n < 300) begin
      tick();
      n++;
    end
    if (done_count < target) check_eq({tag, "_timeout"}, 32'(done_count), 32'(target));
  endtask

  task automatic start_req(input logic wr, input logic [12:0] blk, output int acc);
    int n;
    int a0;
    n = 0;
    a0 = accept_count;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_block = blk;
    while (accept_count == a0 && n < 50) begin
      tick();
      n++;
    end
    bus.req_valid = 1'b0;
    if (accept_count == a0) check_eq("accept_timeout", 32'(accept_count), 32'(a0 + 1));
    acc = last_acc_edge;
  endtask

  // Junk is held on wr_valid while the controller is still in LAT; it must be ignored.
  task automatic write_beats(input logic [12:0] blk, input logic [31:0] base,
                             input int nbeats, input bit gaps, output int last_drive);
    int n;
    n = 0;
    last_drive = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hDEAD_BEEF;
    while (!bus.wr_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("wr_ready", 32'(bus.wr_ready), 32'd1);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && (b == 4 || b == 8 || b == 12)) begin
        bus.wr_valid = 1'b0;
        tick();
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 32'(b);
      model_mem[int'(blk) * 16 + b] = base + 32'(b);
      last_drive = cyc;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ld, d0, a0, n;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_block = 13'd0;
    bus.wr_valid = 1'b0;  bus.wr_data = 32'd0;
    bus_l1.req_valid = 1'b0; bus_l1.req_write = 1'b0; bus_l1.req_block = 13'd0;
    bus_l1.wr_valid = 1'b0;  bus_l1.wr_data = 32'd0;
    bus_l15.req_valid = 1'b0; bus_l15.req_write = 1'b0; bus_l15.req_block = 13'd0;
    bus_l15.wr_valid = 1'b0;  bus_l15.wr_data = 32'd0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check_eq("rst_rd_data",   bus.rd_data,        32'd0);
    check_eq("rst_rd_beat",   32'(bus.rd_beat),   32'd0);
    check_eq("rst_rd_last",   32'(bus.rd_last),   32'd0);
    check_eq("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
    check_eq("rst_done",      32'(bus.done),      32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    rst = 1'b0;
    tick();

    // Plain fill of block 0x0005
    d0 = done_count;
    start_req(1'b0, 13'h0005, acc);
    wait_done(d0 + 1, "fill5");
    check_eq("fill5_first_beat", 32'(first_cyc - acc), 32'd4);
    check_eq("fill5_last_beat",  32'(last_cyc - acc),  32'd19);
    check_eq("fill5_done",       32'(done_cyc - acc),  32'd20);
    check_eq("fill5_sb_empty",   32'(exp_q.size()),    32'd0);
    $display("fill      blk=0x0005 acc=%0d first=%0d done=%0d", acc, first_cyc, done_cyc);
    tick();

    // Writeback 0x1ABC with three gap cycles, then fill it back
    d0 = done_count;
    start_req(1'b1, 13'h1ABC, acc);
    write_beats(13'h1ABC, 32'hA0, 16, 1'b1, ld);
    wait_done(d0 + 1, "wb1abc");
    check_eq("wb1abc_done_after_last", 32'(done_cyc), 32'(ld + 1));
    $display("writeback blk=0x1ABC acc=%0d last_beat_drive=%0d done=%0d", acc, ld, done_cyc);
    tick();
    d0 = done_count;
    start_req(1'b0, 13'h1ABC, acc);
    wait_done(d0 + 1, "fill1abc");
    check_eq("fill1abc_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("fill      blk=0x1ABC acc=%0d done=%0d", acc, done_cyc);
    tick();

    // req_valid held through a fill: one accept, next only after done
    a0 = accept_count;
    d0 = done_count;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_block = 13'h0777;
    wait_done(d0 + 1, "busy1");
    check_eq("busy_single_accept", 32'(accept_count - a0), 32'd1);
    n = 0;
    while (accept_count < a0 + 2 && n < 20) begin
      tick();
      n++;
    end
    bus.req_valid = 1'b0;
    check_eq("busy_second_accept_edge", 32'(last_acc_edge), 32'(done_cyc + 2));
    wait_done(d0 + 2, "busy2");
    check_eq("busy_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("busy-hold blk=0x0777 accepts=%0d", accept_count - a0);
    tick();

    // Reset during fill beat 7
    d0 = done_count;
    start_req(1'b0, 13'h0123, acc);
    n = 0;
    while (!(bus.rd_valid && bus.rd_beat == 4'd7) && n < 50) begin
      tick();
      n++;
    end
    check_eq("midfill_reached_beat7", 32'(bus.rd_beat), 32'd7);
    rst = 1'b1;
    tick();
    check_eq("midfill_rd_valid", 32'(bus.rd_valid),  32'd0);
    check_eq("midfill_busy",     32'(bus.busy),      32'd0);
    check_eq("midfill_req_ready",32'(bus.req_ready), 32'd1);
    check_eq("midfill_beats_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    rst = 1'b0;
    repeat (3) tick();
    check_eq("midfill_no_done", 32'(done_count), 32'(d0));
    $display("fill-rst  blk=0x0123 acc=%0d aborted at beat 7", acc);

    // Reset after 8 writeback beats of 0x0010, then fill it back
    d0 = done_count;
    start_req(1'b1, 13'h0010, acc);
    write_beats(13'h0010, 32'h5500, 8, 1'b0, ld);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midwb_busy",     32'(bus.busy),     32'd0);
    check_eq("midwb_wr_ready", 32'(bus.wr_ready), 32'd0);
    repeat (2) tick();
    check_eq("midwb_no_done", 32'(done_count), 32'(d0));
    $display("wb-rst    blk=0x0010 acc=%0d aborted after 8 beats", acc);
    start_req(1'b0, 13'h0010, acc);
    wait_done(d0 + 1, "fill0010");
    check_eq("fill0010_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("fill      blk=0x0010 acc=%0d done=%0d", acc, done_cyc);
    tick();

    // Latency extremes on the side instances
    bus_l1.req_valid = 1'b1;  bus_l1.req_block = 13'd3;
    bus_l15.req_valid = 1'b1; bus_l15.req_block = 13'd3;
    acc = cyc + 1;
    tick();
    bus_l1.req_valid = 1'b0;
    bus_l15.req_valid = 1'b0;
    n = 0;
    while ((first_l1 < 0 || first_l15 < 0) && n < 40) begin
      tick();
      n++;
    end
    check_eq("lat1_first_beat",  32'(first_l1 - acc),  32'd1);
    check_eq("lat15_first_beat", 32'(first_l15 - acc), 32'd15);
    check_eq("lat15_beat0_data", first_l15_data, 32'd0);
    $display("latency   L1 first=%0d L15 first=%0d acc=%0d", first_l1, first_l15, acc);
    repeat (25) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
